// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - sequenced register-file datapath with shifter, 4-op ALU and VNZ status
//
// Purpose:
//   Register file, A/B operand registers, B-side shifter, 4-op ALU, C result
//   register and {V,N,Z} status register. An internal sequencer runs one
//   whole instruction (load A, load B, execute, write back) per start/done
//   handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        instruction request, accepted only while idle
//   cmd          00 MOV imm, 01 ALU reg-reg, 10 ALU reg-imm, 11 CMP reg-reg
//   ALUop        00 SUM, 01 SUB, 10 AND, 11 NOT
//   shift        B shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1
//   rd/rn/rm     destination / A-operand / B-operand register addresses
//   imm          sign-extended immediate
//   dbg_addr     debug read address
//   dbg_data     combinational R[dbg_addr]
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse in the final state of every instruction
//   datapath_out C register
//   status       {V,N,Z}

module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [1:0]       ALUop,
  input  logic [1:0]       shift,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rn,
  input  logic [AW-1:0]    rm,
  input  logic [WIDTH-1:0] imm,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status
);

  localparam int NREG = 2 ** AW;

  localparam logic [1:0] CMD_MOV = 2'b00;
  localparam logic [1:0] CMD_RI  = 2'b10;
  localparam logic [1:0] CMD_CMP = 2'b11;

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LA   = 3'd1,
    S_LB   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Instruction fields captured on accept; inputs may change freely afterwards.
  logic [1:0]       cmd_q;
  logic [1:0]       aluop_q;
  logic [1:0]       shift_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rn_q;
  logic [AW-1:0]    rm_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] rf_q [NREG];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [2:0]       status_q;

  logic             accept;
  logic [WIDTH-1:0] b_src;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             wb_en;
  logic [WIDTH-1:0] wb_data;

  assign accept = (state_q == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // Sequencer next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_WB);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // MOV needs no operands or ALU pass, so it goes straight to writeback.
          state_d = (cmd == CMD_MOV) ? S_WB : S_LA;
        end
      end
      S_LA:    state_d = S_LB;
      S_LB:    state_d = S_EX;
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand select, shifter and ALU
  // ---------------------------------------------------------------------------
  assign b_src = (cmd_q == CMD_RI) ? imm_q : rf_q[rm_q];

  always_comb begin
    b_shift = b_q;
    case (shift_q)
      SH_NONE: b_shift = b_q;
      SH_LSL:  b_shift = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR:  b_shift = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR:  b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shift = b_q;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (aluop_q)
      OP_SUM: begin
        alu_res = a_q + b_shift;
        // Like-signed operands producing an opposite-signed sum.
        alu_v   = (a_q[WIDTH-1] == b_shift[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a_q - b_shift;
        // Unlike-signed operands where the difference loses A's sign.
        alu_v   = (a_q[WIDTH-1] != b_shift[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = a_q & b_shift;
      OP_NOT:  alu_res = ~b_shift;
      default: alu_res = '0;
    endcase
  end

  // CMP exists only to set flags, so it never writes the register file.
  assign wb_en   = (state_q == S_WB) && (cmd_q != CMD_CMP);
  assign wb_data = (cmd_q == CMD_MOV) ? imm_q : c_q;

  // ---------------------------------------------------------------------------
  // State, latches and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      aluop_q  <= '0;
      shift_q  <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q   <= cmd;
        aluop_q <= ALUop;
        shift_q <= shift;
        rd_q    <= rd;
        rn_q    <= rn;
        rm_q    <= rm;
        imm_q   <= imm;
      end
      if (state_q == S_LA) begin
        a_q <= rf_q[rn_q];
      end
      if (state_q == S_LB) begin
        b_q <= b_src;
      end
      if (state_q == S_EX) begin
        c_q      <= alu_res;
        status_q <= {alu_v, alu_res[WIDTH-1], (alu_res == '0)};
      end
      if (wb_en) begin
        rf_q[rd_q] <= wb_data;
      end
    end
  end

  assign dbg_data     = rf_q[dbg_addr];
  assign datapath_out = c_q;
  assign status       = status_q;

endmodule
